// File: rtl/sram_arb.sv
// Two-requester (IM fetch / DM load-store) arbiter in front of one single-port synchronous SRAM.
// Define SRAM_ARB_RR_EN for round-robin arbitration; otherwise DM has priority with an IM starvation guard.
module sram_arb #(
  parameter int ADDR_WIDTH   = 14,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    im_req,
  input  logic [ADDR_WIDTH-1:0]   im_addr,
  output logic                    im_ready,
  output logic                    im_rvalid,
  output logic [DATA_WIDTH-1:0]   im_rdata,
  input  logic                    dm_req,
  input  logic [ADDR_WIDTH-1:0]   dm_addr,
  input  logic [DATA_WIDTH/8-1:0] dm_wstrb,
  input  logic [DATA_WIDTH-1:0]   dm_wdata,
  output logic                    dm_ready,
  output logic                    dm_rvalid,
  output logic [DATA_WIDTH-1:0]   dm_rdata,
  output logic                    CS,
  output logic [DATA_WIDTH/8-1:0] WE,
  output logic [ADDR_WIDTH-1:0]   A,
  output logic [DATA_WIDTH-1:0]   DI,
  input  logic [DATA_WIDTH-1:0]   DO
);

  localparam logic OWN_IM = 1'b0;
  localparam logic OWN_DM = 1'b1;

  logic                  run_reg;
  logic                  im_win;
  logic                  dm_win;
  logic                  rsp_vld_reg;
  logic                  rsp_own_reg;
  logic [DATA_WIDTH-1:0] im_rdata_reg;
  logic [DATA_WIDTH-1:0] dm_rdata_reg;

  // Grants are held off until the first clock edge after reset release,
  // so every output stays 0 while rstn is low and in the release cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) run_reg <= 1'b0;
    else       run_reg <= 1'b1;
  end

`ifdef SRAM_ARB_RR_EN
  logic last_dm_reg;  // 0 = IM granted last, so DM is favoured after reset

  always_comb begin
    im_win = 1'b0;
    dm_win = 1'b0;
    if (run_reg) begin
      if (im_req && dm_req) begin
        if (last_dm_reg) im_win = 1'b1;
        else             dm_win = 1'b1;
      end else begin
        im_win = im_req;
        dm_win = dm_req;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       last_dm_reg <= 1'b0;
    else if (im_win) last_dm_reg <= 1'b0;
    else if (dm_win) last_dm_reg <= 1'b1;
  end
`else
  logic [3:0] starve_cnt_reg;
  logic       starved;

  assign starved = (starve_cnt_reg == 4'(STARVE_LIMIT));

  always_comb begin
    im_win = 1'b0;
    dm_win = 1'b0;
    if (run_reg) begin
      if (im_req && dm_req) begin
        if (starved) im_win = 1'b1;
        else         dm_win = 1'b1;
      end else begin
        im_win = im_req;
        dm_win = dm_req;
      end
    end
  end

  // Counts consecutive IM denials; cannot pass STARVE_LIMIT because IM wins there.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                          starve_cnt_reg <= 4'd0;
    else if (run_reg && im_req && !im_win) starve_cnt_reg <= starve_cnt_reg + 4'd1;
    else                                starve_cnt_reg <= 4'd0;
  end
`endif

  assign im_ready = im_win;
  assign dm_ready = dm_win;

  always_comb begin
    CS = 1'b0;
    WE = '0;
    A  = '0;
    DI = '0;
    if (dm_win) begin
      CS = 1'b1;
      WE = dm_wstrb;
      A  = dm_addr;
      DI = dm_wdata;
    end else if (im_win) begin
      CS = 1'b1;
      A  = im_addr;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_vld_reg <= 1'b0;
      rsp_own_reg <= OWN_IM;
    end else begin
      rsp_vld_reg <= CS && ~|WE;
      if (CS) rsp_own_reg <= dm_win ? OWN_DM : OWN_IM;
    end
  end

  assign im_rvalid = rsp_vld_reg && (rsp_own_reg == OWN_IM);
  assign dm_rvalid = rsp_vld_reg && (rsp_own_reg == OWN_DM);

  // Read data is DO in the response cycle and the last captured word otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      im_rdata_reg <= '0;
      dm_rdata_reg <= '0;
    end else begin
      if (im_rvalid) im_rdata_reg <= DO;
      if (dm_rvalid) dm_rdata_reg <= DO;
    end
  end

  assign im_rdata = im_rvalid ? DO : im_rdata_reg;
  assign dm_rdata = dm_rvalid ? DO : dm_rdata_reg;

endmodule
